// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: captures write-back results {rd, data} into a first-word-
// fall-through FIFO drained over a valid/ready port. The core is never
// stalled; captures arriving while the FIFO is full are dropped and counted.
// Writes to x0 are filtered out and are not counted as drops.
//
// Optional feature macro: WB_TRACE_CHECKSUM_EN adds a 32-bit running
// signature (rotate-left-1 XOR data XOR rd) over every accepted push.
//
// Handshake: a pop happens on a rising edge where out_valid && out_ready.
// out_valid is high exactly when count != 0, never drops without a pop, and
// out_rd/out_data hold the head entry steady until it is popped.
module wb_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_valid,
    input  logic [IDX_W-1:0]         wb_rd,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_rd,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt,
    input  logic                     clear
`ifdef WB_TRACE_CHECKSUM_EN
    ,
    output logic [31:0]              checksum
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = IDX_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic capture;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // Request decode: x0 writes never reach the FIFO or the drop counter.
    always_comb begin
        capture = wb_valid && (wb_rd != '0);
        full    = (count == FULL_CNT);
        pop     = out_valid && out_ready;
        push    = capture && (!full || pop);
        drop    = capture && full && !pop;
    end

    assign out_valid = (count != '0);

    // Head entry presentation; forced to zero while empty so reset shows zeros.
    always_comb begin
        out_rd   = '0;
        out_data = '0;
        if (out_valid) begin
            {out_rd, out_data} = mem[rd_ptr];
        end
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wb_rd, wb_data};
        end
    end

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Drop statistics; a drop in the same cycle as clear wins (result is 1).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear) begin
                drop_cnt <= 16'd1;
            end else if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (clear) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

`ifdef WB_TRACE_CHECKSUM_EN
    logic [31:0] sum_base;
    logic [31:0] data32;
    logic [31:0] rd32;

    // Checksum inputs: clear restarts the signature from zero in the same cycle.
    always_comb begin
        sum_base = clear ? 32'd0 : {checksum[30:0], checksum[31]};
        data32   = 32'(wb_data);
        rd32     = 32'(wb_rd);
    end

    // Running signature over accepted pushes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum <= '0;
        end else if (push) begin
            checksum <= sum_base ^ data32 ^ rd32;
        end else if (clear) begin
            checksum <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_wb_trace_buffer.sv
// tb_wb_trace_buffer: directed bench for wb_trace_buffer with DEPTH = 4.
// Stimulus pushes expected {rd, data} entries into exp_q; a negedge monitor
// pops and compares whenever the DUT completes a handshake.
module tb_wb_trace_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int IDX_W  = 5;
    localparam int ENT_W  = IDX_W + DATA_W;

    logic              clk;
    logic              reset;
    logic              wb_valid;
    logic [IDX_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_rd;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        count;
    logic              overflow;
    logic [15:0]       drop_cnt;
    logic              clear;
`ifdef WB_TRACE_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    logic [ENT_W-1:0] exp_q[$];
    int n_vec;
    int n_err;

    wb_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rd    (out_rd),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clear     (clear)
`ifdef WB_TRACE_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got rd=%0d data=0x%0h, required no pop", out_rd, out_data);
            end else begin
                logic [ENT_W-1:0] e;
                e = exp_q.pop_front();
                if ({out_rd, out_data} !== e) begin
                    n_err++;
                    $display("FAIL pop_order: got rd=%0d data=0x%0h, required rd=%0d data=0x%0h",
                             out_rd, out_data, e[ENT_W-1:DATA_W], e[DATA_W-1:0]);
                end
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; drives one capture for one cycle.
    task automatic capture(input logic [IDX_W-1:0] rd, input logic [DATA_W-1:0] data, input bit accept);
        if (accept) exp_q.push_back({rd, data});
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = data;
        @(posedge clk); #1;
        wb_valid = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    // Drain with out_ready high, bounded by a cycle budget.
    task automatic drain(input int max_cycles);
        out_ready = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (count == 0) break;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b0;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        out_ready = 1'b0;
        clear     = 1'b0;
        #3;
        chk("rst_valid",    64'(out_valid), 64'd0);
        chk("rst_count",    64'(count),     64'd0);
        chk("rst_overflow", 64'(overflow),  64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt),  64'd0);
        chk("rst_out_rd",   64'(out_rd),    64'd0);
        chk("rst_out_data", 64'(out_data),  64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

`ifdef WB_TRACE_CHECKSUM_EN
        // Checksum from reset
        chk("cks_reset", 64'(checksum), 64'd0);
        capture(5'd1, 32'h100, 1'b1);
        chk("cks_push1", 64'(checksum), 64'h101);
        capture(5'd2, 32'h10, 1'b1);
        chk("cks_push2", 64'(checksum), 64'h210);
        pulse_clear();
        chk("cks_clear", 64'(checksum), 64'd0);
        drain(10);
`endif

        // Ordering and x0 filter
        chk("t1_empty_valid", 64'(out_valid), 64'd0);
        capture(5'd1, 32'h11, 1'b1);
        chk("t1_latency_valid", 64'(out_valid), 64'd1);
        chk("t1_head_rd", 64'(out_rd), 64'd1);
        capture(5'd2, 32'h22, 1'b1);
        capture(5'd0, 32'h33, 1'b0);
        capture(5'd3, 32'h33, 1'b1);
        chk("t1_count", 64'(count), 64'd3);
        chk("t1_no_drop", 64'(drop_cnt), 64'd0);
        drain(10);

        // Overflow
        capture(5'd4, 32'hA0, 1'b1);
        capture(5'd5, 32'hA1, 1'b1);
        capture(5'd6, 32'hA2, 1'b1);
        capture(5'd7, 32'hA3, 1'b1);
        capture(5'd8, 32'hA4, 1'b0);
        chk("t2_count", 64'(count), 64'd4);
        chk("t2_overflow", 64'(overflow), 64'd1);
        chk("t2_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("t2_head_rd", 64'(out_rd), 64'd4);
        chk("t2_head_data", 64'(out_data), 64'hA0);

        // Full with simultaneous push and pop
        out_ready = 1'b1;
        capture(5'd9, 32'h99, 1'b1);
        out_ready = 1'b0;
        chk("t3_count", 64'(count), 64'd4);
        chk("t3_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("t3_head_rd", 64'(out_rd), 64'd5);
        pulse_clear();
        chk("t3_clr_overflow", 64'(overflow), 64'd0);
        chk("t3_clr_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("t3_clr_count", 64'(count), 64'd4);
        clear = 1'b1;
        capture(5'd10, 32'hBB, 1'b0);
        clear = 1'b0;
        chk("t3_clrdrop_overflow", 64'(overflow), 64'd1);
        chk("t3_clrdrop_drop_cnt", 64'(drop_cnt), 64'd1);
        drain(10);

        // Reset mid-operation
        capture(5'd11, 32'hD0, 1'b1);
        capture(5'd12, 32'hD1, 1'b1);
        capture(5'd13, 32'hD2, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("t4_valid", 64'(out_valid), 64'd0);
        chk("t4_count", 64'(count), 64'd0);
        chk("t4_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("t4_overflow", 64'(overflow), 64'd0);
        chk("t4_out_data", 64'(out_data), 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t4_post_valid", 64'(out_valid), 64'd0);
        capture(5'd14, 32'hE0, 1'b1);
        chk("t4_cap_valid", 64'(out_valid), 64'd1);
        chk("t4_cap_count", 64'(count), 64'd1);
        chk("t4_cap_data", 64'(out_data), 64'hE0);
        drain(10);

        // Drop counter saturation
        capture(5'd15, 32'hF0, 1'b1);
        capture(5'd16, 32'hF1, 1'b1);
        capture(5'd17, 32'hF2, 1'b1);
        capture(5'd18, 32'hF3, 1'b1);
        wb_valid = 1'b1;
        wb_rd    = 5'd19;
        wb_data  = 32'hF4;
        repeat (70000) @(posedge clk);
        #1;
        wb_valid = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        chk("t6_drop_cnt_sat", 64'(drop_cnt), 64'hFFFF);
        chk("t6_overflow", 64'(overflow), 64'd1);
        chk("t6_count", 64'(count), 64'd4);
        chk("t6_head_data", 64'(out_data), 64'hF0);
        drain(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Captures the pipeline's write-back results (destination register index and `WB_Data`) into a first-word-fall-through FIFO. A verification or debug consumer drains the FIFO through a valid/ready port. The block sits directly downstream of the `riscv` core's write-back stage. It lets benches and on-chip monitors observe every architectural register write without stalling the core: the core is never back-pressured, and excess entries are dropped and counted.

## Interface
- `DATA_W`, 32, write-back data width.
- `DEPTH`, 16, FIFO entries; power of two, ≥2.
- `IDX_W`, 5, register index width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `wb_valid`  in  1  write-back stage retiring a register write this cycle.
- `wb_rd`  in  IDX_W  destination register index.
- `wb_data`  in  DATA_W  write-back data (the core's `WB_Data`).
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  consumer accepts head entry.
- `out_rd`  out  IDX_W  head entry register index.
- `out_data`  out  DATA_W  head entry data.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `overflow`  out  1  sticky: at least one capture was dropped.
- `drop_cnt`  out  16  dropped captures, saturating at 0xFFFF.
- `clear`  in  1  synchronous clear of `overflow`, `drop_cnt` and `checksum`.
- `checksum`  out  32  running signature; present only with `WB_TRACE_CHECKSUM_EN`.

## Operation
**Capture**
- A capture request is `wb_valid && wb_rd != 0`.
- Writes to x0 are discarded silently and are not counted as drops.

**Push**
- A push is accepted when a capture is requested and either `count < DEPTH`, or `count == DEPTH` with a pop in the same cycle.
- Accepted entries are stored as `{wb_rd, wb_data}` at the write pointer.

**Pop**
- A pop occurs when `out_valid && out_ready`.
- Pops happen in strict FIFO order.
- `out_rd` and `out_data` always reflect the head entry while `out_valid = 1`. They are don't-care while `out_valid = 0`.

**Pointers and occupancy**
- Pointers are `$clog2(DEPTH)`-bit and wrap modulo DEPTH.
- `count` is the registered occupancy:
  - +1 on push only;
  - −1 on pop only;
  - unchanged on simultaneous push and pop.
- `out_valid` = (`count != 0`).

**Drop**
- A drop is a capture request with `count == DEPTH` and no pop in that cycle.
- On a drop, `overflow` is set to 1 and `drop_cnt` increments (saturating).
- FIFO contents are untouched.

**Clear**
- `clear` zeroes `overflow` and `drop_cnt`.
- If a drop occurs in the same cycle as `clear`, the drop wins over the clear for that cycle: `overflow = 1`, `drop_cnt = 1`.
- `clear` does not affect FIFO contents or `count`.

**State machine**
- The block has no explicit FSM. Its state is the pointers, `count`, the storage array and the statistics registers.

## Timing
**Reset**
- All state is cleared asynchronously on `reset = 0`. It is released synchronously on the first rising edge with `reset = 1`.
- Reset values: `out_valid = 0`, `count = 0`, `overflow = 0`, `drop_cnt = 0`, `checksum = 0`, `out_rd = 0`, `out_data = 0`, pointers = 0. Storage contents are don't-care.

**Latency**
- A capture at edge N makes `out_valid = 1` after edge N when the FIFO was empty. There is no same-cycle bypass.

**Throughput**
- Sustained rate is one push and one pop per cycle.

**Reset mid-operation**
- All entries are lost and outputs go to their reset values immediately, without waiting for a clock edge.

**Handshake**
- The consumer may hold `out_ready` high continuously.
- `out_valid` never deasserts without a pop.
- `out_rd`/`out_data` must not change while `out_valid && !out_ready`.

## Configuration
- **`WB_TRACE_CHECKSUM_EN` defined:**
  - On every accepted push, `checksum <= rotl1(checksum) ^ wb_data ^ zero_ext(wb_rd)`, where `rotl1` is a 1-bit left rotate of the 32-bit value.
  - `DATA_W` is zero-extended or truncated to 32 bits.
  - Cleared by reset and by `clear`. If an accepted push coincides with `clear`, the update is applied to 0.
- **Not defined:**
  - The `checksum` port and its register are absent.
  - All other behaviour is identical.

## Test plan
1. **Ordering and x0 filter.** With `out_ready = 0`, apply captures (1, 0x11), (2, 0x22), (0, 0x33), (3, 0x33). Expect `count = 3`. Then raise `out_ready`: expect pops (1, 0x11), (2, 0x22), (3, 0x33), then `count = 0` and `out_valid = 0`.
2. **Overflow.** With `DEPTH = 4` and `out_ready = 0`, apply 5 captures. Expect `count = 4`, `overflow = 1`, `drop_cnt = 1`, and the head entry equal to the first capture.
3. **Full with push and pop.** With `DEPTH = 4`, full, and a capture while `out_ready = 1`: expect no drop, `count` stays 4, and the newest entry popped last. Then assert `clear` together with a drop: expect `overflow = 1`, `drop_cnt = 1`.
4. **Reset mid-operation.** With 3 entries queued, assert `reset = 0` between clock edges. Expect `out_valid = 0`, `count = 0` and `drop_cnt = 0` immediately. After release, a single capture appears one cycle later.
5. **Checksum (macro defined).** From reset, push (1, 0x100) and expect `checksum = 0x101`. Then push (2, 0x10) and expect `checksum = 0x210`. Then assert `clear` and expect `checksum = 0`.
6. **Drop counter saturation.** Apply 70000 drops and expect `drop_cnt = 0xFFFF` with no wrap.
